// File: rtl/pau_pkg.sv
// Shared constants for the posit arithmetic unit: default posit format,
// derived field widths and the NaR bit pattern.
package pau_pkg;

    localparam int unsigned DEF_N   = 32;
    localparam int unsigned DEF_ES  = 3;
    localparam int unsigned DEF_BS  = 5;

    localparam int unsigned SCALE_W = DEF_ES + DEF_BS + 1;
    localparam int unsigned MANT_W  = DEF_N - DEF_ES - 2;

    localparam logic [DEF_N-1:0] NAR = {1'b1, {(DEF_N-1){1'b0}}};

endpackage

// File: rtl/posit_run_cnt.sv
// Regime run-length counter: length of the run of bits equal to the MSB of vec,
// scanning from the MSB downward. The result never exceeds N-1.
module posit_run_cnt #(
    parameter int unsigned N  = 32,
    parameter int unsigned Bs = 5
) (
    input  logic [N-2:0]  vec,
    output logic          run_bit,
    output logic [Bs-1:0] run_len
);

    localparam logic [Bs-1:0] ONE = {{(Bs-1){1'b0}}, 1'b1};

    logic stop;

    always_comb begin
        run_bit = vec[N-2];
        run_len = '0;
        stop    = 1'b0;
        for (int unsigned i = 0; i < N - 1; i++) begin
            if (!stop && (vec[N-2-i] == vec[N-2])) begin
                run_len = run_len + ONE;
            end else begin
                stop = 1'b1;
            end
        end
    end

endmodule

// File: rtl/posit_decode_pipe.sv
// Two-stage posit decoder: stage 1 takes the magnitude and counts the regime run,
// stage 2 extracts exponent and fraction and packs regime and exponent into one scale.
module posit_decode_pipe
    import pau_pkg::*;
#(
    parameter int unsigned N  = DEF_N,
    parameter int unsigned es = DEF_ES,
    parameter int unsigned Bs = DEF_BS
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [N-1:0]    posit_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic            sign_o,
    output logic            zero_o,
    output logic            nar_o,
    output logic [es+Bs:0]  scale_o,
    output logic [N-es-3:0] mant_o
);

    localparam int unsigned SW = es + Bs + 1;
    localparam int unsigned MW = N - es - 2;
    localparam int unsigned RW = es + MW - 1;
    localparam logic [N-1:0] NAR_W = {1'b1, {(N-1){1'b0}}};
    localparam logic [Bs:0]  K_ONE = {{Bs{1'b0}}, 1'b1};

    logic s1_valid;
    logic s2_valid;
    logic s1_adv;
    logic s2_adv;
    logic accept;

    assign s2_adv  = !s2_valid || ready_i;
    assign s1_adv  = !s1_valid || s2_adv;
    assign ready_o = s1_adv;
    assign accept  = valid_i && s1_adv;
    assign valid_o = s2_valid;

    // Only the low N-1 bits of the magnitude are needed past the sign.
    logic [N-2:0]  abs_lo;
    logic          run_bit;
    logic [Bs-1:0] run_len;

    assign abs_lo = posit_i[N-1] ? -posit_i[N-2:0] : posit_i[N-2:0];

    posit_run_cnt #(
        .N  (N),
        .Bs (Bs)
    ) u_run_cnt (
        .vec     (abs_lo),
        .run_bit (run_bit),
        .run_len (run_len)
    );

    logic          s1_sign;
    logic          s1_zero;
    logic          s1_nar;
    logic          s1_rc;
    logic [Bs-1:0] s1_m;
    logic [N-2:0]  s1_body;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_zero  <= 1'b0;
            s1_nar   <= 1'b0;
            s1_rc    <= 1'b0;
            s1_m     <= '0;
            s1_body  <= '0;
        end else begin
            if (flush_i) begin
                s1_valid <= 1'b0;
            end else if (s1_adv) begin
                s1_valid <= valid_i;
            end
            if (accept) begin
                s1_sign <= posit_i[N-1];
                s1_zero <= (posit_i == '0);
                s1_nar  <= (posit_i == NAR_W);
                s1_rc   <= run_bit;
                s1_m    <= run_len;
                s1_body <= abs_lo;
            end
        end
    end

    // Bits [N-3:1] of body<<m equal bits [N-2:2] of body<<(m+1); the two low
    // bits of the latter are always zero because the run is at least one long.
    logic [RW-1:0] rem;
    logic [Bs:0]   k;
    logic [es-1:0] e;
    logic [SW-1:0] scale_n;
    logic [MW-1:0] mant_n;

    always_comb begin
        rem     = RW'((s1_body << s1_m) >> 1);
        k       = s1_rc ? ({1'b0, s1_m} - K_ONE) : -{1'b0, s1_m};
        e       = rem[RW-1 -: es];
        scale_n = {k, e};
        mant_n  = {1'b1, rem[MW-2:0]};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s2_valid <= 1'b0;
            sign_o   <= 1'b0;
            zero_o   <= 1'b0;
            nar_o    <= 1'b0;
            scale_o  <= '0;
            mant_o   <= '0;
        end else begin
            if (flush_i) begin
                s2_valid <= 1'b0;
            end else if (s2_adv) begin
                s2_valid <= s1_valid;
            end
            if (s2_adv && s1_valid) begin
                sign_o  <= s1_sign;
                zero_o  <= s1_zero;
                nar_o   <= s1_nar;
                scale_o <= (s1_zero || s1_nar) ? '0 : scale_n;
                mant_o  <= (s1_zero || s1_nar) ? '0 : mant_n;
            end
        end
    end

endmodule
